csw_recorder: RTL and testbench

- Tape recorder counterpart to the tape player: samples the machine's cassette-out level on `ce` ticks and measures edge-to-edge pulse lengths.
- Encodes each length as a CSW-style byte stream and writes it to tape RAM through a ready/strobe handshake.
- Sits between the machine's tape output and the shared tape buffer. Host saves `size` bytes from address 0.

---
 rtl/csw_recorder.sv | 220 ++++++++++++++++++++++
 tb/tb_csw_recorder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csw_recorder.sv
`default_nettype none
// ============================================================================
// Module   : csw_recorder
// Purpose  : Samples the machine's cassette-out level on ce ticks, measures
//            edge-to-edge pulse lengths and writes each length to tape RAM
//            as a CSW-style byte stream through a ready/strobe handshake.
//            Lengths 1..255 are one byte; longer lengths are a 0x00 marker
//            followed by the 32-bit length, little-endian.
// Ports    : clock/reset  - clock, asynchronous active-low reset
//            ce, tape     - sample strobe and cassette-out level
//            rec, stop    - one-clock start / end of recording pulses
//            busy         - armed or recording
//            a, q, we     - write address, data and request (held until
//            ready          accepted on an edge with we=1 and ready=1)
//            size         - bytes written in this recording (saturating)
//            full,overrun - sticky buffer-full and lost-pulse flags
// Revision : 1.0 - initial release
// ============================================================================
module csw_recorder #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          tape,
    input  logic          rec,
    input  logic          stop,
    output logic          busy,
    output logic [AW-1:0] a,
    output logic [7:0]    q,
    output logic          we,
    input  logic          ready,
    output logic [AW-1:0] size,
    output logic          full,
    output logic          overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_WR2  = 3'd5,
        S_WR3  = 3'd6,
        S_WR4  = 3'd7
    } state_t;

    localparam logic [AW-1:0] C_ADDR_ONE = AW'(1);
    localparam logic [AW-1:0] C_ADDR_MAX = '1;
    localparam logic [31:0]   C_CNT_MAX  = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] size_q, size_d;
    logic [7:0]  q_q, q_d;
    logic        we_q, we_d;
    logic        full_q, full_d;
    logic        overrun_q, overrun_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [31:0] plen_q, plen_d;      // measured length waiting to be written
    logic [31:0] wlen_q, wlen_d;      // length currently being written
    logic        last_q, last_d;

    logic [31:0] w_cnt_inc;
    logic        w_edge;
    logic        w_timing;
    logic        w_xfer;

    // cnt+1 saturating doubles as the length of the pulse ending on this tick
    assign w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 32'd1;
    assign w_edge    = ce && (tape != last_q);
    assign w_timing  = (state_q != S_IDLE) && (state_q != S_ARM);
    assign w_xfer    = we_q && ready;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        size_d    = size_q;
        q_d       = q_q;
        we_d      = we_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        plen_d    = plen_q;
        wlen_d    = wlen_q;
        last_d    = last_q;

        if (stop) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
        end else if (rec) begin
            state_d   = S_ARM;
            a_d       = '0;
            size_d    = '0;
            we_d      = 1'b0;
            full_d    = 1'b0;
            overrun_d = 1'b0;
            cnt_d     = '0;
            pending_d = 1'b0;
            last_d    = tape;
        end else begin
            // Pulse measurement runs alongside the writer in RUN and WRx.
            if (state_q == S_ARM && w_edge) begin
                last_d  = tape;
                cnt_d   = '0;
                state_d = S_RUN;
            end else if (w_timing && ce) begin
                if (w_edge) begin
                    last_d = tape;
                    cnt_d  = '0;
                    // A full one-entry slot at the tick loses the new length.
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                        plen_d    = w_cnt_inc;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end

            case (state_q)
                S_RUN: begin
                    if (pending_q) begin
                        pending_d = 1'b0;
                        wlen_d    = plen_q;
                        q_d       = (plen_q > 32'd255) ? 8'h00 : plen_q[7:0];
                        we_d      = 1'b1;
                        state_d   = S_WR0;
                    end
                end
                S_WR0, S_WR1, S_WR2, S_WR3, S_WR4: begin
                    if (w_xfer) begin
                        a_d    = a_q + C_ADDR_ONE;
                        size_d = (size_q == C_ADDR_MAX) ? size_q : size_q + C_ADDR_ONE;
                        if (a_q == C_ADDR_MAX) begin
                            // Last cell written: the rest of a long entry is dropped.
                            full_d  = 1'b1;
                            we_d    = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            case (state_q)
                                S_WR0: begin
                                    if (wlen_q > 32'd255) begin
                                        q_d     = wlen_q[7:0];
                                        state_d = S_WR1;
                                    end else begin
                                        we_d    = 1'b0;
                                        state_d = S_RUN;
                                    end
                                end
                                S_WR1: begin
                                    q_d     = wlen_q[15:8];
                                    state_d = S_WR2;
                                end
                                S_WR2: begin
                                    q_d     = wlen_q[23:16];
                                    state_d = S_WR3;
                                end
                                S_WR3: begin
                                    q_d     = wlen_q[31:24];
                                    state_d = S_WR4;
                                end
                                default: begin
                                    we_d    = 1'b0;
                                    state_d = S_RUN;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            size_q    <= '0;
            q_q       <= '0;
            we_q      <= 1'b0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            plen_q    <= '0;
            wlen_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            size_q    <= size_d;
            q_q       <= q_d;
            we_q      <= we_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            plen_q    <= plen_d;
            wlen_q    <= wlen_d;
            last_q    <= last_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign a       = a_q;
    assign q       = q_q;
    assign we      = we_q;
    assign size    = size_q;
    assign full    = full_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_csw_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csw_recorder
// Purpose  : Self-checking bench for csw_recorder. Two instances (AW=16 and
//            AW=4) share all stimulus; each is compared every clock against
//            a behavioural model, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csw_recorder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0, tape = 1'b0, rec = 1'b0, stop = 1'b0, ready = 1'b0;

    logic        busy16, we16, full16, ov16;
    logic [15:0] a16, size16;
    logic [7:0]  q16;
    logic        busy4, we4, full4, ov4;
    logic [3:0]  a4, size4;
    logic [7:0]  q4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    csw_recorder #(.AW(16)) dut16 (
        .clock(clock), .reset(reset), .ce(ce), .tape(tape), .rec(rec), .stop(stop),
        .busy(busy16), .a(a16), .q(q16), .we(we16), .ready(ready),
        .size(size16), .full(full16), .overrun(ov16)
    );

    csw_recorder #(.AW(4)) dut4 (
        .clock(clock), .reset(reset), .ce(ce), .tape(tape), .rec(rec), .stop(stop),
        .busy(busy4), .a(a4), .q(q4), .we(we4), .ready(ready),
        .size(size4), .full(full4), .overrun(ov4)
    );

    // ------------------------------------------------------------------
    // Behavioural model: 0 = idle, 1 = armed, 2 = recording. While a
    // recording has bytes queued they are presented one at a time.
    // ------------------------------------------------------------------
    int unsigned m_st[2], m_a[2], m_size[2], m_cnt[2], m_plen[2];
    bit          m_full[2], m_ov[2], m_pend[2], m_last[2];
    bit [7:0]    m_by[2][5];
    int          m_bn[2], m_bi[2];

    function automatic int unsigned mask(int k);
        return (k == 0) ? 32'h0000_FFFF : 32'h0000_000F;
    endfunction

    function automatic void m_reset(int k);
        m_st[k] = 0; m_a[k] = 0; m_size[k] = 0; m_cnt[k] = 0; m_plen[k] = 0;
        m_full[k] = 0; m_ov[k] = 0; m_pend[k] = 0; m_last[k] = 0;
        m_bn[k] = 0; m_bi[k] = 0;
        for (int j = 0; j < 5; j++) m_by[k][j] = 8'h00;
    endfunction

    function automatic int unsigned sat_inc(int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic void m_step(int k);
        int unsigned st0;
        bit          p0;
        st0 = m_st[k];
        p0  = m_pend[k];
        if (stop) begin
            m_st[k] = 0;
            m_bn[k] = 0;
        end else if (rec) begin
            m_st[k] = 1; m_a[k] = 0; m_size[k] = 0; m_full[k] = 0; m_ov[k] = 0;
            m_cnt[k] = 0; m_pend[k] = 0; m_last[k] = tape; m_bn[k] = 0;
        end else if (st0 != 0) begin
            if (m_bn[k] > 0) begin
                if (ready) begin
                    if (m_size[k] != mask(k)) m_size[k] = m_size[k] + 1;
                    if (m_a[k] == mask(k)) begin
                        m_full[k] = 1; m_bn[k] = 0; m_st[k] = 0; m_a[k] = 0;
                    end else begin
                        m_a[k] = m_a[k] + 1; m_bi[k] = m_bi[k] + 1; m_bn[k] = m_bn[k] - 1;
                    end
                end
            end else if (st0 == 2 && p0) begin
                m_pend[k] = 0;
                m_bi[k]   = 0;
                if (m_plen[k] <= 255) begin
                    m_by[k][0] = 8'(m_plen[k]);
                    m_bn[k]    = 1;
                end else begin
                    m_by[k][0] = 8'h00;
                    for (int j = 0; j < 4; j++) m_by[k][j+1] = 8'(m_plen[k] >> (8*j));
                    m_bn[k] = 5;
                end
            end
            if (ce && (tape != m_last[k])) begin
                m_last[k] = tape;
                if (st0 == 1) begin
                    m_st[k]  = 2;
                    m_cnt[k] = 0;
                end else begin
                    if (p0) m_ov[k] = 1;
                    else begin
                        m_pend[k] = 1;
                        m_plen[k] = sat_inc(m_cnt[k]);
                    end
                    m_cnt[k] = 0;
                end
            end else if (ce && st0 == 2) begin
                m_cnt[k] = sat_inc(m_cnt[k]);
            end
        end
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0);
            m_step(1);
            cyc = cyc + 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic b, input logic w, input logic [31:0] aa,
                       input logic [7:0] qq, input logic [31:0] ss, input logic f, input logic o);
        bit       eb, ew;
        bit [7:0] eq;
        eb = (m_st[k] != 0);
        ew = (m_bn[k] > 0);
        eq = ew ? m_by[k][m_bi[k]] : 8'h00;
        checks++;
        if (b !== eb || w !== ew || aa !== m_a[k] || ss !== m_size[k] || f !== m_full[k] ||
            o !== m_ov[k] || (ew && qq !== eq)) begin
            errors++;
            $display("FAIL model_aw%0d t=%0t: got busy=%b we=%b a=%0h q=%0h size=%0h full=%b ovr=%b, want busy=%b we=%b a=%0h q=%0h size=%0h full=%b ovr=%b",
                     (k == 0) ? 16 : 4, $time, b, w, aa, qq, ss, f, o,
                     eb, ew, m_a[k], eq, m_size[k], m_full[k], m_ov[k]);
        end
    endtask

    // Accepted-transfer log of each instance.
    int unsigned lg_a[$], lg_q[$], lg_t[$];
    int n4 = 0;

    always @(negedge clock) begin
        cmp(0, busy16, we16, 32'(a16), q16, 32'(size16), full16, ov16);
        cmp(1, busy4, we4, 32'(a4), q4, 32'(size4), full4, ov4);
        if (we16 && ready) begin
            lg_a.push_back(32'(a16));
            lg_q.push_back(32'(q16));
            lg_t.push_back(cyc);
        end
        if (we4 && ready) n4++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
        rec  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        repeat (n) tick();
    endtask

    task automatic start_rec();
        lg_a.delete(); lg_q.delete(); lg_t.delete();
        n4  = 0;
        ce  = 1'b0;
        rec = 1'b1;
        tick();
    endtask

    task automatic first_edge();
        tape = ~tape;
        ce   = 1'b1;
        tick();
        ce   = 1'b0;
    endtask

    // Next edge arrives len ce ticks after the previous one.
    task automatic pulse(input int len);
        ce = 1'b1;
        repeat (len - 1) tick();
        tape = ~tape;
        tick();
        ce = 1'b0;
    endtask

    task automatic wait_we(input string nm, input int lim);
        for (int i = 0; i < lim && !we16; i++) tick();
        chk(nm, 32'(we16), 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_outputs_aw16", {busy16, we16, full16, ov16, q16, a16}, 32'd0);
        chk("reset_size_aw16", 32'(size16), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        idle(2);

        // Three 10-tick pulses.
        ready = 1'b1;
        start_rec();
        chk("armed_busy", 32'(busy16), 32'd1);
        first_edge();
        repeat (3) pulse(10);
        idle(20);
        chk("t1_count", lg_a.size(), 32'd3);
        for (int i = 0; i < 3 && i < lg_a.size(); i++) begin
            chk("t1_addr", lg_a[i], i);
            chk("t1_data", lg_q[i], 32'h0A);
        end
        chk("t1_size", 32'(size16), 32'd3);
        chk("t1_overrun", 32'(ov16), 32'd0);

        // One 300-tick pulse, ready tied high: long form on consecutive clocks.
        start_rec();
        first_edge();
        pulse(300);
        idle(20);
        chk("t2_count", lg_a.size(), 32'd5);
        if (lg_a.size() == 5) begin
            chk("t2_b0", lg_q[0], 32'h00);
            chk("t2_b1", lg_q[1], 32'h2C);
            chk("t2_b2", lg_q[2], 32'h01);
            chk("t2_b3", lg_q[3], 32'h00);
            chk("t2_b4", lg_q[4], 32'h00);
            chk("t2_addr4", lg_a[4], 32'd4);
            chk("t2_back_to_back", lg_t[4] - lg_t[0], 32'd4);
        end
        chk("t2_size", 32'(size16), 32'd5);

        // ready held low: request held stable, transfer on first ready.
        ready = 1'b0;
        start_rec();
        first_edge();
        pulse(7);
        wait_we("t3_we_rises", 10);
        repeat (20) tick();
        chk("t3_hold_we", 32'(we16), 32'd1);
        chk("t3_hold_a", 32'(a16), 32'd0);
        chk("t3_hold_q", 32'(q16), 32'd7);
        chk("t3_hold_size", 32'(size16), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t3_size_after", 32'(size16), 32'd1);
        chk("t3_we_after", 32'(we16), 32'd0);

        // Edges while stalled: first pending length kept, third one lost.
        start_rec();
        first_edge();
        pulse(5);
        pulse(6);
        pulse(7);
        idle(5);
        chk("t4_overrun", 32'(ov16), 32'd1);
        chk("t4_stalled_size", 32'(size16), 32'd0);
        ready = 1'b1;
        idle(10);
        chk("t4_count", lg_q.size(), 32'd2);
        if (lg_q.size() == 2) begin
            chk("t4_first", lg_q[0], 32'd5);
            chk("t4_second", lg_q[1], 32'd6);
        end

        // AW=4 instance fills up with 1-tick pulses.
        start_rec();
        ce = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tape = ~tape;
            tick();
        end
        chk("t5_full4", 32'(full4), 32'd1);
        chk("t5_busy4", 32'(busy4), 32'd0);
        chk("t5_we4", 32'(we4), 32'd0);
        chk("t5_size4", 32'(size4), 32'd15);
        chk("t5_writes4", n4, 32'd16);
        for (int i = 0; i < 10; i++) begin
            tape = ~tape;
            tick();
        end
        chk("t5_no_more_writes4", n4, 32'd16);
        ce = 1'b0;
        stop = 1'b1;
        tick();

        // stop with an un-accepted byte; rec+stop together.
        ready = 1'b0;
        start_rec();
        first_edge();
        pulse(4);
        wait_we("t6_we_rises", 10);
        stop = 1'b1;
        tick();
        chk("t6_we_dropped", 32'(we16), 32'd0);
        chk("t6_size", 32'(size16), 32'd0);
        chk("t6_idle", 32'(busy16), 32'd0);
        rec  = 1'b1;
        stop = 1'b1;
        tick();
        chk("t6_rec_stop_idle", 32'(busy16), 32'd0);

        // Reset in the middle of a long entry (third byte presented).
        ready = 1'b1;
        start_rec();
        first_edge();
        pulse(300);
        for (int i = 0; i < 20 && !(we16 && size16 == 16'd2); i++) tick();
        chk("t7_in_wr2", {16'(size16), 7'd0, we16, q16}, {16'd2, 7'd0, 1'b1, 8'h01});
        #2 reset = 1'b0;
        #1;
        chk("t7_async_reset_aw16", {busy16, we16, full16, ov16, q16, a16}, 32'd0);
        chk("t7_async_reset_size", 32'(size16), 32'd0);
        chk("t7_async_reset_aw4", {12'd0, busy4, we4, full4, ov4, q4, a4}, 32'd0);
        tick();
        reset = 1'b1;
        idle(2);

        // Randomised traffic with short, medium and long pulse mixes.
        for (int seg = 0; seg < 40; seg++) begin
            int unsigned tp;
            tp = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 20 : 400);
            for (int i = 0; i < 500; i++) begin
                ce    = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, tp - 1) == 0) tape = ~tape;
                ready = (seg % 4 == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
                rec   = (!busy16 && $urandom_range(0, 30) == 0) || ($urandom_range(0, 3000) == 0);
                stop  = ($urandom_range(0, 4000) == 0);
                tick();
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
